// File: rtl/cache_mem_arbiter.sv
// Shares one single-beat memory port between icache refills and dcache refills/writebacks.
// Optional CACHE_ARB_RR_EN: round-robin read grant (default build: dc read beats ic read).
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BEATS  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ic_rd_req_i,
  input  logic [ADDR_W-1:0]       ic_rd_addr_i,
  output logic                    ic_rd_rdy_o,
  output logic [DATA_W-1:0]       ic_rd_data_o,
  output logic [2:0]              ic_rd_num_o,
  input  logic                    dc_rd_req_i,
  input  logic [ADDR_W-1:0]       dc_rd_addr_i,
  output logic                    dc_rd_rdy_o,
  output logic [DATA_W-1:0]       dc_rd_data_o,
  output logic [2:0]              dc_rd_num_o,
  input  logic                    dc_wr_req_i,
  input  logic [ADDR_W-1:0]       dc_wr_addr_i,
  input  logic [BEATS*DATA_W-1:0] dc_wr_data_i,
  output logic                    dc_wr_rdy_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic [DATA_W-1:0]       mem_wdata_o,
  input  logic                    mem_ack_i,
  input  logic [DATA_W-1:0]       mem_rdata_i
);

  localparam int BW  = $clog2(BEATS);
  localparam int OFS = $clog2(BEATS * DATA_W / 8);

  typedef enum logic [1:0] {IDLE, WB, RF} state_t;

  state_t                          state, state_nxt;
  logic                            wb_valid;
  logic [ADDR_W-OFS-1:0]           wb_base;
  logic [BEATS-1:0][DATA_W-1:0]    wb_line;
  logic [ADDR_W-OFS-1:0]           rd_base;
  logic                            gnt_dc;
  logic [BW-1:0]                   beat;
  logic                            grant, grant_dc;
  logic                            wb_capture, beat_done, last_beat, rd_fire;
  logic                            unused_addr_bits;

  assign unused_addr_bits = ^{ic_rd_addr_i[OFS-1:0], dc_rd_addr_i[OFS-1:0], dc_wr_addr_i[OFS-1:0]};

  assign dc_wr_rdy_o = !wb_valid;
  assign wb_capture  = dc_wr_req_i && !wb_valid;
  assign beat_done   = (state != IDLE) && mem_ack_i;
  assign last_beat   = beat_done && (beat == BW'(BEATS - 1));
  assign rd_fire     = (state == RF) && mem_ack_i;

  assign mem_req_o   = (state != IDLE);
  assign mem_we_o    = (state == WB);
  assign mem_addr_o  = mem_req_o ? {((state == WB) ? wb_base : rd_base), beat, {(OFS-BW){1'b0}}}
                                 : '0;
  assign mem_wdata_o = (state == WB) ? wb_line[beat] : '0;

`ifdef CACHE_ARB_RR_EN
  logic last_dc;
  // On a tie the requester that did not win last time goes first.
  wire  pick_dc = dc_rd_req_i && (!ic_rd_req_i || !last_dc);
`else
  wire  pick_dc = dc_rd_req_i;
`endif

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_dc  = 1'b0;
    case (state)
      IDLE: begin
        // A writeback landing this very cycle must still beat any read to memory.
        if (wb_valid || wb_capture) begin
          state_nxt = WB;
        end else if (ic_rd_req_i || dc_rd_req_i) begin
          state_nxt = RF;
          grant     = 1'b1;
          grant_dc  = pick_dc;
        end
      end
      WB, RF: begin
        if (last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat     <= '0;
      wb_valid <= 1'b0;
      wb_base  <= '0;
      wb_line  <= '0;
      rd_base  <= '0;
      gnt_dc   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (beat_done) beat <= last_beat ? '0 : beat + 1'b1;
      if (wb_capture) begin
        wb_valid <= 1'b1;
        wb_base  <= dc_wr_addr_i[ADDR_W-1:OFS];
        wb_line  <= dc_wr_data_i;
      end else if ((state == WB) && last_beat) begin
        wb_valid <= 1'b0;
      end
      if (grant) begin
        gnt_dc  <= grant_dc;
        rd_base <= grant_dc ? dc_rd_addr_i[ADDR_W-1:OFS] : ic_rd_addr_i[ADDR_W-1:OFS];
      end
    end
  end

`ifdef CACHE_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_dc <= 1'b0;
    else if (grant) last_dc <= grant_dc;
  end
`endif

  // Read beats come back one cycle after their ack; data/num hold between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ic_rd_rdy_o  <= 1'b0;
      ic_rd_data_o <= '0;
      ic_rd_num_o  <= '0;
      dc_rd_rdy_o  <= 1'b0;
      dc_rd_data_o <= '0;
      dc_rd_num_o  <= '0;
    end else begin
      ic_rd_rdy_o <= rd_fire && !gnt_dc;
      dc_rd_rdy_o <= rd_fire && gnt_dc;
      if (rd_fire && !gnt_dc) begin
        ic_rd_data_o <= mem_rdata_i;
        ic_rd_num_o  <= 3'(beat);
      end
      if (rd_fire && gnt_dc) begin
        dc_rd_data_o <= mem_rdata_i;
        dc_rd_num_o  <= 3'(beat);
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: stimulus pushes expected memory beats and read
// returns; negedge monitors model the memory, pop and compare.
module tb_cache_mem_arbiter;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ic_rd_req_i, dc_rd_req_i, dc_wr_req_i;
  logic [31:0]   ic_rd_addr_i, dc_rd_addr_i, dc_wr_addr_i;
  logic [127:0]  dc_wr_data_i;
  logic          ic_rd_rdy_o, dc_rd_rdy_o, dc_wr_rdy_o;
  logic [31:0]   ic_rd_data_o, dc_rd_data_o;
  logic [2:0]    ic_rd_num_o, dc_rd_num_o;
  logic          mem_req_o, mem_we_o;
  logic [31:0]   mem_addr_o, mem_wdata_o;
  logic          mem_ack_i = 1'b0;
  logic [31:0]   mem_rdata_i = 32'h0;

  always #5 clk = ~clk;

  cache_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ic_rd_req_i(ic_rd_req_i), .ic_rd_addr_i(ic_rd_addr_i), .ic_rd_rdy_o(ic_rd_rdy_o),
    .ic_rd_data_o(ic_rd_data_o), .ic_rd_num_o(ic_rd_num_o),
    .dc_rd_req_i(dc_rd_req_i), .dc_rd_addr_i(dc_rd_addr_i), .dc_rd_rdy_o(dc_rd_rdy_o),
    .dc_rd_data_o(dc_rd_data_o), .dc_rd_num_o(dc_rd_num_o),
    .dc_wr_req_i(dc_wr_req_i), .dc_wr_addr_i(dc_wr_addr_i), .dc_wr_data_i(dc_wr_data_i),
    .dc_wr_rdy_o(dc_wr_rdy_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } mem_exp_t;
  typedef struct { logic is_dc; logic [2:0] num; logic [31:0] data; } rd_exp_t;

  mem_exp_t exp_mem[$];
  rd_exp_t  exp_rd[$];

  int checks = 0, errors = 0;
  int ack_dly = 1, wait_cnt = 0, ack_cnt = 0, cur_len = 0, last_len = 0;
  logic [31:0] prev_addr, prev_wdata;
  logic        prev_we;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_line(input logic is_dc, input logic [31:0] base, input int n_mem, input int n_rd);
    for (int b = 0; b < n_mem; b++)
      exp_mem.push_back('{we: 1'b0, addr: base + 32'(4*b), wdata: 32'h0});
    for (int b = 0; b < n_rd; b++)
      exp_rd.push_back('{is_dc: is_dc, num: 3'(b), data: mem_val(base + 32'(4*b))});
  endtask

  task automatic push_wb(input logic [31:0] base, input logic [127:0] line);
    for (int b = 0; b < 4; b++)
      exp_mem.push_back('{we: 1'b1, addr: base + 32'(4*b), wdata: line[32*b +: 32]});
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_mem_req"},   mem_req_o,    0);
    check({tag, "_mem_we"},    mem_we_o,     0);
    check({tag, "_mem_addr"},  mem_addr_o,   0);
    check({tag, "_mem_wdata"}, mem_wdata_o,  0);
    check({tag, "_ic_rdy"},    ic_rd_rdy_o,  0);
    check({tag, "_ic_data"},   ic_rd_data_o, 0);
    check({tag, "_ic_num"},    ic_rd_num_o,  0);
    check({tag, "_dc_rdy"},    dc_rd_rdy_o,  0);
    check({tag, "_dc_data"},   dc_rd_data_o, 0);
    check({tag, "_dc_num"},    dc_rd_num_o,  0);
    check({tag, "_wr_rdy"},    dc_wr_rdy_o,  1);
  endtask

  // Waits for the last beat of a read, then drops that requester's request.
  task automatic wait_beat3(input string name, input logic is_dc);
    int n = 0;
    logic seen = 1'b0;
    while (!seen && n < 500) begin
      @(negedge clk); #1; n++;
      seen = is_dc ? (dc_rd_rdy_o && dc_rd_num_o == 3'd3) : (ic_rd_rdy_o && ic_rd_num_o == 3'd3);
    end
    check({name, "_last_beat_seen"}, seen, 1);
    if (is_dc) dc_rd_req_i = 1'b0;
    else       ic_rd_req_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    logic done = 1'b0;
    while (!done && n < 1000) begin
      @(negedge clk); #1; n++;
      done = (exp_mem.size() == 0) && (exp_rd.size() == 0) && !mem_req_o;
    end
    check({name, "_drained"}, done, 1);
    @(negedge clk); #1;
  endtask

  // Memory model plus memory-side monitor.
  always @(negedge clk) begin : mem_model
    mem_exp_t e;
    if (mem_req_o) begin
      cur_len++;
      if (wait_cnt > 0) begin
        check("mem_hold_we",    mem_we_o,    prev_we);
        check("mem_hold_addr",  mem_addr_o,  prev_addr);
        check("mem_hold_wdata", mem_wdata_o, prev_wdata);
      end
      prev_we    = mem_we_o;
      prev_addr  = mem_addr_o;
      prev_wdata = mem_wdata_o;
      if (wait_cnt == ack_dly) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = mem_val(mem_addr_o);
        wait_cnt    = 0;
        ack_cnt++;
        if (exp_mem.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_beat: unexpected beat we=%0b addr=%h", mem_we_o, mem_addr_o);
        end else begin
          e = exp_mem.pop_front();
          check("mem_we",   mem_we_o,   e.we);
          check("mem_addr", mem_addr_o, e.addr);
          if (e.we) check("mem_wdata", mem_wdata_o, e.wdata);
        end
      end else begin
        mem_ack_i = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack_i = 1'b0;
      wait_cnt  = 0;
      if (cur_len != 0) begin
        last_len = cur_len;
        cur_len  = 0;
      end
    end
  end

  // Read-return monitor.
  always @(negedge clk) begin : rd_monitor
    rd_exp_t e;
    if (ic_rd_rdy_o || dc_rd_rdy_o) begin
      check("rd_one_requester", ic_rd_rdy_o && dc_rd_rdy_o, 0);
      if (exp_rd.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_beat: unexpected pulse ic=%0b dc=%0b", ic_rd_rdy_o, dc_rd_rdy_o);
      end else begin
        e = exp_rd.pop_front();
        check("rd_requester", dc_rd_rdy_o, e.is_dc);
        check("rd_num",  dc_rd_rdy_o ? dc_rd_num_o  : ic_rd_num_o,  e.num);
        check("rd_data", dc_rd_rdy_o ? dc_rd_data_o : ic_rd_data_o, e.data);
      end
    end
  end

  initial begin
    int base_acks, n, dc_phase;
    rst_n = 1'b0;
    ic_rd_req_i = 0; dc_rd_req_i = 0; dc_wr_req_i = 0;
    ic_rd_addr_i = 0; dc_rd_addr_i = 0; dc_wr_addr_i = 0; dc_wr_data_i = 0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 1: icache refill, unaligned address
    push_line(1'b0, 32'h1230, 4, 4);
    ic_rd_addr_i = 32'h0000_1234; ic_rd_req_i = 1'b1;
    wait_beat3("t1", 1'b0);
    wait_drain("t1");
    check("t1_burst_len", last_len, 8);

    // 2: dcache writeback
    push_wb(32'h2040, 128'h44444444_33333333_22222222_11111111);
    check("t2_wr_rdy_idle", dc_wr_rdy_o, 1);
    dc_wr_addr_i = 32'h0000_2040;
    dc_wr_data_i = 128'h44444444_33333333_22222222_11111111;
    dc_wr_req_i  = 1'b1;
    @(negedge clk);
    dc_wr_req_i = 1'b0;
    check("t2_wr_rdy_busy", dc_wr_rdy_o, 0);
    wait_drain("t2");
    check("t2_wr_rdy_back", dc_wr_rdy_o, 1);

    // 3: two tie decisions in a row (dc re-requests immediately)
`ifdef CACHE_ARB_RR_EN
    push_line(1'b1, 32'h8000, 4, 4);
    push_line(1'b0, 32'h7000, 4, 4);
    push_line(1'b1, 32'h9000, 4, 4);
`else
    push_line(1'b1, 32'h8000, 4, 4);
    push_line(1'b1, 32'h9000, 4, 4);
    push_line(1'b0, 32'h7000, 4, 4);
`endif
    ic_rd_addr_i = 32'h7000; dc_rd_addr_i = 32'h8000;
    ic_rd_req_i = 1'b1; dc_rd_req_i = 1'b1;
    dc_phase = 0; n = 0;
    while ((ic_rd_req_i || dc_rd_req_i) && n < 800) begin
      @(negedge clk); #1; n++;
      if (dc_rd_rdy_o && dc_rd_num_o == 3'd3) begin
        if (dc_phase == 0) begin dc_rd_addr_i = 32'h9000; dc_phase = 1; end
        else dc_rd_req_i = 1'b0;
      end
      if (ic_rd_rdy_o && ic_rd_num_o == 3'd3) ic_rd_req_i = 1'b0;
    end
    check("t3_all_served", ic_rd_req_i || dc_rd_req_i, 0);
    wait_drain("t3");

    // 4: writeback and dc read in the same cycle
    push_wb(32'h3000, 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000);
    push_line(1'b1, 32'h4000, 4, 4);
    dc_wr_addr_i = 32'h3000; dc_wr_data_i = 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000;
    dc_rd_addr_i = 32'h4000;
    dc_wr_req_i = 1'b1; dc_rd_req_i = 1'b1;
    @(negedge clk);
    dc_wr_req_i = 1'b0;
    wait_beat3("t4", 1'b1);
    wait_drain("t4");

    // 5: slow memory, 5 stall cycles per beat
    ack_dly = 5;
    push_wb(32'hA000, 128'h0BADF00D_CAFEBABE_12345678_DEADBEEF);
    dc_wr_addr_i = 32'hA000; dc_wr_data_i = 128'h0BADF00D_CAFEBABE_12345678_DEADBEEF;
    dc_wr_req_i = 1'b1;
    @(negedge clk);
    dc_wr_req_i = 1'b0;
    wait_drain("t5");
    check("t5_burst_len", last_len, 24);
    ack_dly = 1;

    // 6: reset after the second ack of an ic refill
    push_line(1'b0, 32'h5000, 2, 1);
    base_acks = ack_cnt;
    ic_rd_addr_i = 32'h5008; ic_rd_req_i = 1'b1;
    n = 0;
    while (ack_cnt < base_acks + 2 && n < 200) begin
      @(negedge clk); #1; n++;
    end
    check("t6_two_acks", ack_cnt - base_acks, 2);
    @(posedge clk); #1;
    rst_n = 1'b0; ic_rd_req_i = 1'b0;
    #1;
    check_reset("t6_rst");
    repeat (3) @(negedge clk);
    check("t6_no_pending", exp_mem.size() + exp_rd.size(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    push_line(1'b0, 32'h6000, 4, 4);
    ic_rd_addr_i = 32'h600C; ic_rd_req_i = 1'b1;
    wait_beat3("t6", 1'b0);
    wait_drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
